// File: rtl/im_fetch_ctrl.sv
// Program counter sequencer for the instruction fetch stage.
// It handles stalls, D-stage redirects, exception entry/return and a fetch counter.
//
// state | meaning
// RUN   | normal fetch; PC advances, redirects or holds
// HOLD  | redirect captured behind a stall; released when the stall drops
module im_fetch_ctrl #(
   parameter logic [31:0] START_ADDR = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
   parameter int          IM_WORDS   = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic        addr_exc,
   output logic        redirect_pending,
   output logic [31:0] fetch_cnt
);

   localparam logic [31:0] LAST_ADDR = START_ADDR + 32'(IM_WORDS * 4) - 32'd4;

   typedef enum logic {RUN, HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic [31:0] cnt_q, cnt_d;

   assign pc               = pc_q;
   assign pc_plus4         = pc_q + 32'd4;
   assign addr_exc         = (pc_q[1:0] != 2'b00) | (pc_q < START_ADDR) | (pc_q > LAST_ADDR);
   assign fetch_valid      = ~addr_exc;
   assign redirect_pending = (state_q == HOLD);
   assign fetch_cnt        = cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= RUN;
         pc_q    <= START_ADDR;
         tgt_q   <= 32'd0;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;

      if (fetch_valid && !stall && !exc_req && !eret_req) begin
         cnt_d = cnt_q + 32'd1;
      end

      unique case (state_q)
         RUN: begin
            if (exc_req) begin
               pc_d = EXC_VECTOR;
            end else if (eret_req) begin
               pc_d = epc;
            end else if (stall && redirect_valid) begin
               tgt_d   = redirect_target;
               state_d = HOLD;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (redirect_valid) begin
               pc_d = redirect_target;
            end else if (addr_exc) begin
               // Faulting PC parks here until the exception is taken.
               pc_d = pc_q;
            end else begin
               pc_d = pc_plus4;
            end
         end
         HOLD: begin
            if (exc_req) begin
               pc_d    = EXC_VECTOR;
               tgt_d   = 32'd0;
               state_d = RUN;
            end else if (eret_req) begin
               pc_d    = epc;
               tgt_d   = 32'd0;
               state_d = RUN;
            end else if (stall) begin
               if (redirect_valid) tgt_d = redirect_target;
            end else begin
               // A redirect arriving now comes from a squashed delay slot.
               pc_d    = tgt_q;
               tgt_d   = 32'd0;
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl: expected post-edge outputs are queued with
// each stimulus step and checked one edge later.
module tb_im_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset, stall, redirect_valid, exc_req, eret_req;
   logic [31:0] redirect_target, epc;
   logic [31:0] pc, pc_plus4, fetch_cnt;
   logic        fetch_valid, addr_exc, redirect_pending;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        fv;
      logic        ae;
      logic        pend;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   im_fetch_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .stall            (stall),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
      .exc_req          (exc_req),
      .eret_req         (eret_req),
      .epc              (epc),
      .pc               (pc),
      .pc_plus4         (pc_plus4),
      .fetch_valid      (fetch_valid),
      .addr_exc         (addr_exc),
      .redirect_pending (redirect_pending),
      .fetch_cnt        (fetch_cnt)
   );

   task automatic step(input string tag,
                       input logic rst, input logic st, input logic rv,
                       input logic [31:0] tgt, input logic exc, input logic eret,
                       input logic [31:0] ep,
                       input logic [31:0] e_pc, input logic e_ae,
                       input logic e_pend, input logic [31:0] e_cnt);
      exp_t e;
      reset = rst; stall = st; redirect_valid = rv; redirect_target = tgt;
      exc_req = exc; eret_req = eret; epc = ep;
      e.pc = e_pc; e.pc4 = e_pc + 32'd4; e.ae = e_ae; e.fv = ~e_ae;
      e.pend = e_pend; e.cnt = e_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      tests++;
      assert (pc === e.pc) else begin
         fails++; $error("FAIL %s pc: got %h expected %h", tag, pc, e.pc);
      end
      tests++;
      assert (pc_plus4 === e.pc4) else begin
         fails++; $error("FAIL %s pc_plus4: got %h expected %h", tag, pc_plus4, e.pc4);
      end
      tests++;
      assert (addr_exc === e.ae) else begin
         fails++; $error("FAIL %s addr_exc: got %b expected %b", tag, addr_exc, e.ae);
      end
      tests++;
      assert (fetch_valid === e.fv) else begin
         fails++; $error("FAIL %s fetch_valid: got %b expected %b", tag, fetch_valid, e.fv);
      end
      tests++;
      assert (redirect_pending === e.pend) else begin
         fails++; $error("FAIL %s redirect_pending: got %b expected %b", tag, redirect_pending, e.pend);
      end
      tests++;
      assert (fetch_cnt === e.cnt) else begin
         fails++; $error("FAIL %s fetch_cnt: got %h expected %h", tag, fetch_cnt, e.cnt);
      end
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      exc_req = 1'b0; eret_req = 1'b0; epc = '0;
      //    tag          rst st rv target        exc eret epc           pc            ae pend cnt
      step("reset0",     0, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3000, 0, 0, 0);
      step("reset1",     0, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3000, 0, 0, 0);
      step("seq1",       1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3004, 0, 0, 1);
      step("seq2",       1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3008, 0, 0, 2);
      step("seq3",       1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h300C, 0, 0, 3);
      step("seq4",       1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3010, 0, 0, 4);
      step("stall_rd",   1, 1, 1, 32'h3100,    0, 0, 32'h0,       32'h3010, 0, 1, 4);
      step("stall2",     1, 1, 0, 32'h0,       0, 0, 32'h0,       32'h3010, 0, 1, 4);
      step("release",    1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3100, 0, 0, 5);
      step("mis_rd",     1, 0, 1, 32'h3002,    0, 0, 32'h0,       32'h3002, 1, 0, 6);
      step("mis_idle1",  1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3002, 1, 0, 6);
      step("mis_idle2",  1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3002, 1, 0, 6);
      step("mis_idle3",  1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3002, 1, 0, 6);
      step("mis_exc",    1, 0, 0, 32'h0,       1, 0, 32'h0,       32'h4180, 0, 0, 6);
      step("vec_next",   1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h4184, 0, 0, 7);
      step("last_rd",    1, 0, 1, 32'h6FFC,    0, 0, 32'h0,       32'h6FFC, 0, 0, 8);
      step("over_end",   1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h7000, 1, 0, 9);
      step("over_hold",  1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h7000, 1, 0, 9);
      step("eret",       1, 0, 0, 32'h0,       0, 1, 32'h3020,    32'h3020, 0, 0, 9);
      step("exc_eret",   1, 0, 0, 32'h0,       1, 1, 32'h3040,    32'h4180, 0, 0, 9);
      step("run_a",      1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h4184, 0, 0, 10);
      step("hold_a",     1, 1, 1, 32'h3200,    0, 0, 32'h0,       32'h4184, 0, 1, 10);
      step("hold_latest",1, 1, 1, 32'h3300,    0, 0, 32'h0,       32'h4184, 0, 1, 10);
      step("hold_squash",1, 0, 1, 32'h3400,    0, 0, 32'h0,       32'h3300, 0, 0, 11);
      step("hold_b",     1, 1, 1, 32'h3500,    0, 0, 32'h0,       32'h3300, 0, 1, 11);
      step("hold_exc",   1, 1, 0, 32'h0,       1, 0, 32'h0,       32'h4180, 0, 0, 11);
      step("run_b",      1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h4184, 0, 0, 12);
      step("below_rd",   1, 0, 1, 32'h2FFC,    0, 0, 32'h0,       32'h2FFC, 1, 0, 13);
      step("below_exc",  1, 0, 0, 32'h0,       1, 0, 32'h0,       32'h4180, 0, 0, 13);
      step("wrap_rd",    1, 0, 1, 32'hFFFFFFFC,0, 0, 32'h0,       32'hFFFFFFFC, 1, 0, 14);
      step("wrap_exc",   1, 0, 0, 32'h0,       1, 0, 32'h0,       32'h4180, 0, 0, 14);
      step("hold_c",     1, 1, 1, 32'h3100,    0, 0, 32'h0,       32'h4180, 0, 1, 14);
      step("hold_rst",   0, 1, 0, 32'h0,       0, 0, 32'h0,       32'h3000, 0, 0, 0);
      step("post_rst",   1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3004, 0, 0, 1);
      step("post_rst2",  1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3008, 0, 0, 2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/im_fetch_ctrl.md
Name: im_fetch_ctrl

Overview:
- Sequences the program counter that addresses the instruction memory in the pipelined MIPS core.
- Legal fetch window: 0x00003000 up to 4096 words.
- Applies hazard-unit stalls, D-stage branch/jump redirects, exception entry and ERET return.
- Buffers a redirect that arrives during a stall, flags illegal fetch addresses, and keeps a retired-fetch counter.

Parameters:
- START_ADDR, 32'h00003000, reset PC and base of the instruction memory window
- EXC_VECTOR, 32'h00004180, exception handler entry PC
- IM_WORDS, 4096, instruction memory depth in words; legal PCs are START_ADDR to START_ADDR+4*IM_WORDS-4

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block
- stall  input  1  hazard unit: hold PC this cycle
- redirect_valid  input  1  branch/jump taken in D stage
- redirect_target  input  32  branch/jump destination
- exc_req  input  1  exception committed; go to EXC_VECTOR
- eret_req  input  1  ERET committed; return to epc
- epc  input  32  return address from CP0
- pc  output  32  current fetch address, drives instruction memory
- pc_plus4  output  32  pc + 4, modulo 2^32
- fetch_valid  output  1  pc is legal and the fetched word may enter F/D
- addr_exc  output  1  pc misaligned or outside the window (AdEL on fetch)
- redirect_pending  output  1  a redirect is buffered behind a stall
- fetch_cnt  output  32  count of valid fetches accepted

Behaviour:
- Reset (reset==0 at a clk edge):
  - pc=START_ADDR, fetch_cnt=0, pending flag=0, pending target=0, state=RUN.
  - Outputs after reset: fetch_valid=1, addr_exc=0, redirect_pending=0.
- Combinational outputs:
  - pc_plus4 = pc+4.
  - addr_exc = (pc[1:0]!=0) | (pc<START_ADDR) | (pc>START_ADDR+4*IM_WORDS-4), using unsigned compares.
  - fetch_valid = ~addr_exc.
  - redirect_pending = (state==HOLD).
- State RUN, next PC chosen by priority, highest first:
  1. exc_req: pc<=EXC_VECTOR. Discard any redirect.
  2. eret_req: pc<=epc.
  3. stall & redirect_valid: pc holds; capture redirect_target; go to HOLD.
  4. stall: pc holds.
  5. redirect_valid: pc<=redirect_target.
  6. addr_exc: pc holds and waits for exc_req.
  7. Otherwise: pc<=pc_plus4.
- State HOLD:
  1. exc_req: pc<=EXC_VECTOR, clear buffer, go to RUN.
  2. eret_req: pc<=epc, clear buffer, go to RUN.
  3. stall: hold. A new redirect_valid overwrites the buffered target (latest wins).
  4. ~stall: pc<=buffered target, clear buffer, go to RUN. A redirect_valid in that same cycle is ignored, because it belongs to a delay-slot instruction that is already squashed.
- fetch_cnt:
  - Increments by 1 on every edge where fetch_valid & ~stall & ~exc_req & ~eret_req.
  - Wraps 0xFFFFFFFF -> 0.
  - Not cleared by exceptions.
- Latency:
  - Every PC update lands exactly one cycle after its request.
  - A redirect buffered in HOLD lands one cycle after stall deasserts.
- exc_req and eret_req together: exc_req wins.
- Reset mid-operation: clears HOLD and the buffered target in the same edge, regardless of other inputs.
- No combinational path from any input to pc. Input-to-output combinational paths exist only through addr_exc/fetch_valid (from pc) and redirect_pending (from state).

Test Plan:
- Reset release, no stall, 4 cycles:
  - pc goes 0x3000, 0x3004, 0x3008, 0x300C.
  - fetch_cnt=3 on the 4th cycle; fetch_valid=1 throughout.
- At pc=0x3010, stall=1 for 2 cycles with redirect_valid=1 and target=0x3100 in the first stall cycle:
  - pc stays 0x3010 and redirect_pending=1 for both cycles.
  - Cycle after the stall drops: pc=0x3100, redirect_pending=0.
  - fetch_cnt unchanged during the stall.
- Redirect to 0x3002:
  - addr_exc=1, fetch_valid=0, pc holds 0x3002 for 3 idle cycles.
  - Then exc_req=1 -> pc=0x4180, addr_exc=0.
- Redirect to 0x7000 (beyond the last legal address 0x6FFC):
  - addr_exc=1.
  - Then eret_req=1 with epc=0x3020 -> pc=0x3020.
- exc_req and eret_req in the same cycle, epc=0x3040 -> pc=0x4180.
- In HOLD with target 0x3100, reset=0 for one cycle, then stall=0:
  - pc=0x3000, redirect_pending=0, fetch_cnt=0.
  - Next cycle pc=0x3004; 0x3100 is never fetched.
